attack_sequencer: RTL and testbench

//  Sequences player attacks for the weapon subsystem. Turns raw mouse clicks into timed melee swings or archer shots,

---
 rtl/attack_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_attack_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attack_sequencer.sv
// attack_sequencer: turns mouse clicks into timed melee swings or archer shots
// (windup / active / cooldown windows counted in frame ticks) and merges melee
// and projectile hits into one damage strobe toward the boss logic.
module attack_sequencer #(
    parameter logic [7:0] MELEE_WINDUP_FR    = 8'd2,
    parameter logic [7:0] MELEE_ACTIVE_FR    = 8'd6,
    parameter logic [7:0] MELEE_COOLDOWN_FR  = 8'd10,
    parameter logic [7:0] ARCHER_COOLDOWN_FR = 8'd20,
    parameter logic [7:0] MELEE_DMG          = 8'd10,
    parameter logic [7:0] ARCHER_DMG         = 8'd6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [1:0] game_active,
    input  logic [1:0] char_class,
    input  logic       mouse_clicked,
    input  logic       projectile_busy,
    input  logic       melee_hit,
    input  logic       proj_hit,
    output logic       swing_start,
    output logic       fire_req,
    output logic [1:0] attack_phase,
    output logic       damage_strobe,
    output logic [7:0] damage_amount,
    output logic [7:0] cooldown_left
);
    typedef enum logic [1:0] {
        PH_IDLE     = 2'd0,
        PH_WINDUP   = 2'd1,
        PH_ACTIVE   = 2'd2,
        PH_COOLDOWN = 2'd3
    } phase_t;

    localparam logic [1:0] CLASS_MELEE  = 2'b01;
    localparam logic [1:0] CLASS_ARCHER = 2'b10;
    localparam logic [1:0] GAME_OFF     = 2'b00;

    phase_t     state_r, state_s;
    logic [7:0] counter_r, counter_s;
    logic [1:0] class_r, class_s;
    logic       click_d_r, proj_hit_d_r;
    logic       pending_r, pending_s;
    logic       credited_r, credited_s;
    logic       proj_pend_r, proj_pend_s;
    logic       swing_start_r, swing_start_s;
    logic       fire_req_r, fire_req_s;
    logic       damage_strobe_r, damage_strobe_s;
    logic [7:0] damage_amount_r, damage_amount_s;
    logic [7:0] cooldown_left_r, cooldown_left_s;
    logic       click_edge_s, proj_edge_s, tick_expire_s, melee_credit_s;

    assign click_edge_s  = mouse_clicked & ~click_d_r;
    assign proj_edge_s   = proj_hit & ~proj_hit_d_r;
    // A window ends on the tick that finds one tick remaining.
    assign tick_expire_s = frame_tick & (counter_r == 8'd1);

    assign swing_start   = swing_start_r;
    assign fire_req      = fire_req_r;
    assign attack_phase  = state_r;
    assign damage_strobe = damage_strobe_r;
    assign damage_amount = damage_amount_r;
    assign cooldown_left = cooldown_left_r;

    // Next-state, window counter, hit crediting and output pulse decode.
    always_comb begin
        state_s         = state_r;
        counter_s       = counter_r;
        class_s         = class_r;
        pending_s       = pending_r;
        credited_s      = credited_r;
        proj_pend_s     = proj_pend_r;
        swing_start_s   = 1'b0;
        fire_req_s      = 1'b0;
        damage_strobe_s = 1'b0;
        damage_amount_s = 8'd0;
        melee_credit_s  = 1'b0;

        if (game_active == GAME_OFF) begin
            // Leaving play aborts everything silently.
            state_s     = PH_IDLE;
            counter_s   = 8'd0;
            pending_s   = 1'b0;
            credited_s  = 1'b0;
            proj_pend_s = 1'b0;
        end else begin
            case (state_r)
                PH_IDLE: begin
                    if (click_edge_s | pending_r) begin
                        pending_s = 1'b0;
                        class_s   = char_class;
                        if (char_class == CLASS_MELEE) begin
                            state_s   = PH_WINDUP;
                            counter_s = MELEE_WINDUP_FR;
                        end else if ((char_class == CLASS_ARCHER) && !projectile_busy) begin
                            state_s    = PH_COOLDOWN;
                            counter_s  = ARCHER_COOLDOWN_FR;
                            fire_req_s = 1'b1;
                        end else begin
                            // Busy archer or unarmed: the request is dropped.
                            state_s = PH_IDLE;
                        end
                    end else begin
                        state_s = PH_IDLE;
                    end
                end
                PH_WINDUP: begin
                    if (tick_expire_s) begin
                        state_s       = PH_ACTIVE;
                        counter_s     = MELEE_ACTIVE_FR;
                        swing_start_s = 1'b1;
                        credited_s    = 1'b0;
                    end else if (frame_tick) begin
                        counter_s = counter_r - 8'd1;
                    end else begin
                        counter_s = counter_r;
                    end
                end
                PH_ACTIVE: begin
                    // Only the first overlap of a swing is credited.
                    if (melee_hit && !credited_r && (class_r == CLASS_MELEE)) begin
                        melee_credit_s = 1'b1;
                        credited_s     = 1'b1;
                    end else begin
                        credited_s = credited_r;
                    end
                    if (tick_expire_s) begin
                        state_s   = PH_COOLDOWN;
                        counter_s = MELEE_COOLDOWN_FR;
                    end else if (frame_tick) begin
                        counter_s = counter_r - 8'd1;
                    end else begin
                        counter_s = counter_r;
                    end
                end
                PH_COOLDOWN: begin
                    // One click is remembered; extra clicks are absorbed.
                    if (click_edge_s) begin
                        pending_s = 1'b1;
                    end else begin
                        pending_s = pending_r;
                    end
                    if (tick_expire_s) begin
                        state_s   = PH_IDLE;
                        counter_s = 8'd0;
                    end else if (frame_tick) begin
                        counter_s = counter_r - 8'd1;
                    end else begin
                        counter_s = counter_r;
                    end
                end
                default: begin
                    state_s   = PH_IDLE;
                    counter_s = 8'd0;
                end
            endcase

            // Melee wins a collision; the projectile hit is deferred one cycle.
            if (melee_credit_s) begin
                damage_strobe_s = 1'b1;
                damage_amount_s = MELEE_DMG;
                if (proj_edge_s | proj_pend_r) begin
                    proj_pend_s = 1'b1;
                end else begin
                    proj_pend_s = proj_pend_r;
                end
            end else if (proj_edge_s | proj_pend_r) begin
                damage_strobe_s = 1'b1;
                damage_amount_s = ARCHER_DMG;
                proj_pend_s     = 1'b0;
            end else begin
                proj_pend_s = proj_pend_r;
            end
        end

        if (state_s == PH_COOLDOWN) begin
            cooldown_left_s = counter_s;
        end else begin
            cooldown_left_s = 8'd0;
        end
    end

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= PH_IDLE;
            counter_r       <= 8'd0;
            class_r         <= 2'b00;
            click_d_r       <= 1'b0;
            proj_hit_d_r    <= 1'b0;
            pending_r       <= 1'b0;
            credited_r      <= 1'b0;
            proj_pend_r     <= 1'b0;
            swing_start_r   <= 1'b0;
            fire_req_r      <= 1'b0;
            damage_strobe_r <= 1'b0;
            damage_amount_r <= 8'd0;
            cooldown_left_r <= 8'd0;
        end else begin
            state_r         <= state_s;
            counter_r       <= counter_s;
            class_r         <= class_s;
            click_d_r       <= mouse_clicked;
            proj_hit_d_r    <= proj_hit;
            pending_r       <= pending_s;
            credited_r      <= credited_s;
            proj_pend_r     <= proj_pend_s;
            swing_start_r   <= swing_start_s;
            fire_req_r      <= fire_req_s;
            damage_strobe_r <= damage_strobe_s;
            damage_amount_r <= damage_amount_s;
            cooldown_left_r <= cooldown_left_s;
        end
    end
endmodule

// File: tb/tb_attack_sequencer.sv
// Bench for attack_sequencer: behavioural model compared every cycle, directed
// scenarios with literal expectations, then randomized play.
module tb_attack_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick, mouse_clicked, projectile_busy, melee_hit, proj_hit;
    logic [1:0] game_active, char_class;
    logic       swing_start, fire_req, damage_strobe;
    logic [1:0] attack_phase;
    logic [7:0] damage_amount, cooldown_left;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    attack_sequencer dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
        .char_class(char_class), .mouse_clicked(mouse_clicked),
        .projectile_busy(projectile_busy), .melee_hit(melee_hit), .proj_hit(proj_hit),
        .swing_start(swing_start), .fire_req(fire_req), .attack_phase(attack_phase),
        .damage_strobe(damage_strobe), .damage_amount(damage_amount),
        .cooldown_left(cooldown_left)
    );

    // ---------------- behavioural model ----------------
    int m_phase, m_left;                  // phase 0..3, frame ticks left in window
    bit m_click_d, m_proj_d, m_pend, m_cred, m_proj_owed;
    bit e_swing, e_fire, e_strobe;
    int e_amt, e_cd;

    function automatic void model_reset();
        m_phase = 0; m_left = 0;
        m_click_d = 0; m_proj_d = 0; m_pend = 0; m_cred = 0; m_proj_owed = 0;
        e_swing = 0; e_fire = 0; e_strobe = 0; e_amt = 0; e_cd = 0;
    endfunction

    function automatic void model_step();
        bit ce, pe, melee_str;
        int p0;
        ce = mouse_clicked && !m_click_d;
        pe = proj_hit && !m_proj_d;
        m_click_d = mouse_clicked;
        m_proj_d  = proj_hit;
        e_swing = 0; e_fire = 0; e_strobe = 0; e_amt = 0;
        melee_str = 0;
        p0 = m_phase;
        if (game_active == 2'b00) begin
            m_phase = 0; m_left = 0; m_pend = 0; m_cred = 0; m_proj_owed = 0;
        end else begin
            if (p0 == 0) begin
                if (ce || m_pend) begin
                    m_pend = 0;
                    if (char_class == 2'b01) begin
                        m_phase = 1; m_left = 2;
                    end else if (char_class == 2'b10 && !projectile_busy) begin
                        m_phase = 3; m_left = 20; e_fire = 1;
                    end
                end
            end else begin
                if (p0 == 2 && melee_hit && !m_cred) begin
                    melee_str = 1; m_cred = 1;
                end
                if (p0 == 3 && ce) m_pend = 1;
                if (frame_tick) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (p0 == 1) begin
                            m_phase = 2; m_left = 6; e_swing = 1; m_cred = 0;
                        end else if (p0 == 2) begin
                            m_phase = 3; m_left = 10;
                        end else begin
                            m_phase = 0;
                        end
                    end
                end
            end
            if (melee_str) begin
                e_strobe = 1; e_amt = 10;
                if (pe) m_proj_owed = 1;
            end else if (pe || m_proj_owed) begin
                e_strobe = 1; e_amt = 6; m_proj_owed = 0;
            end
        end
        e_cd = (m_phase == 3) ? m_left : 0;
    endfunction

    // ---------------- observation ----------------
    int n_swing, n_fire, n_strobe, max_cd;
    int ph_ticks[4];
    int tr_ph[$];
    int tr_t[$];
    int st_amt[$];
    int st_t[$];
    logic [1:0] last_ph;

    task automatic clear_obs();
        n_swing = 0; n_fire = 0; n_strobe = 0; max_cd = 0;
        for (int i = 0; i < 4; i++) ph_ticks[i] = 0;
        tr_ph.delete(); tr_t.delete(); st_amt.delete(); st_t.delete();
        last_ph = attack_phase;
    endtask

    task automatic check_outputs();
        checks++;
        if (swing_start !== e_swing || fire_req !== e_fire || attack_phase !== 2'(m_phase) ||
            damage_strobe !== e_strobe || damage_amount !== 8'(e_amt) || cooldown_left !== 8'(e_cd)) begin
            errors++;
            $display("FAIL model cycle %0d: dut phase=%0d swing=%0b fire=%0b strobe=%0b amt=%0d cd=%0d ; required phase=%0d swing=%0b fire=%0b strobe=%0b amt=%0d cd=%0d",
                     cyc, attack_phase, swing_start, fire_req, damage_strobe, damage_amount, cooldown_left,
                     m_phase, e_swing, e_fire, e_strobe, e_amt, e_cd);
        end
    endtask

    task automatic expect_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // One clock: model advances at the edge, DUT checked on the falling edge.
    task automatic step();
        if (frame_tick) ph_ticks[attack_phase]++;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        check_outputs();
        if (swing_start) n_swing++;
        if (fire_req) n_fire++;
        if (damage_strobe) begin
            n_strobe++;
            st_amt.push_back(int'(damage_amount));
            st_t.push_back(cyc);
        end
        if (int'(cooldown_left) > max_cd) max_cd = int'(cooldown_left);
        if (attack_phase != last_ph) begin
            tr_ph.push_back(int'(attack_phase));
            tr_t.push_back(cyc);
            last_ph = attack_phase;
        end
    endtask

    task automatic run(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            frame_tick = (i % period) == (period - 1);
            step();
        end
        frame_tick = 1'b0;
    endtask

    task automatic click();
        frame_tick = 1'b0;
        mouse_clicked = 1'b1;
        step();
        mouse_clicked = 1'b0;
    endtask

    task automatic wait_phase(input int p, input int budget, input int period);
        bit found;
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            if (int'(attack_phase) == p) begin
                found = 1;
            end else begin
                frame_tick = (i % period) == (period - 1);
                step();
            end
        end
        frame_tick = 1'b0;
        if (!found && int'(attack_phase) == p) found = 1;
        expect_int($sformatf("wait for phase %0d", p), int'(found), 1);
    endtask

    task automatic quiet(input logic [1:0] cls);
        frame_tick = 1'b0; mouse_clicked = 1'b0; projectile_busy = 1'b0;
        melee_hit = 1'b0; proj_hit = 1'b0; game_active = 2'b01; char_class = cls;
    endtask

    initial begin
        int exp_seq[4];
        int exp_seq2[8];
        int toggles;
        rst = 1'b1;
        quiet(2'b01);
        game_active = 2'b00;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        expect_int("reset outputs", int'({swing_start, fire_req, damage_strobe, attack_phase,
                                          damage_amount, cooldown_left}), 0);
        rst = 1'b0;
        game_active = 2'b01;
        step();

        // 1: melee window lengths with a tick every 4 clocks
        quiet(2'b01);
        clear_obs();
        click();
        run(90, 4);
        expect_int("windup ticks", ph_ticks[1], 2);
        expect_int("active ticks", ph_ticks[2], 6);
        expect_int("cooldown ticks", ph_ticks[3], 10);
        expect_int("swing_start pulses", n_swing, 1);
        expect_int("phase transitions", tr_ph.size(), 4);
        exp_seq = '{1, 2, 3, 0};
        for (int i = 0; i < 4 && i < tr_ph.size(); i++)
            expect_int($sformatf("phase seq[%0d]", i), tr_ph[i], exp_seq[i]);

        // 2: melee_hit held across the whole attack credits exactly one hit
        quiet(2'b01);
        melee_hit = 1'b1;
        clear_obs();
        click();
        run(90, 4);
        melee_hit = 1'b0;
        expect_int("melee strobes", n_strobe, 1);
        if (st_amt.size() > 0) expect_int("melee amount", st_amt[0], 10);

        // 3: archer shot, then a shot refused while the projectile is busy
        quiet(2'b10);
        clear_obs();
        click();
        expect_int("model archer cooldown", e_cd, 20);
        expect_int("archer cooldown start", int'(cooldown_left), 20);
        run(100, 4);
        expect_int("fire_req pulses", n_fire, 1);
        expect_int("max cooldown_left", max_cd, 20);
        expect_int("cooldown_left after", int'(cooldown_left), 0);
        expect_int("archer phase after", int'(attack_phase), 0);
        projectile_busy = 1'b1;
        clear_obs();
        click();
        run(10, 4);
        expect_int("busy fire_req", n_fire, 0);
        expect_int("busy phase changes", tr_ph.size(), 0);

        // 4: triple click in cooldown queues exactly one follow-up attack
        quiet(2'b01);
        clear_obs();
        click();
        toggles = 0;
        for (int i = 0; i < 150; i++) begin
            frame_tick = (i % 2) == 1;
            if (attack_phase == 2'd3 && tr_ph.size() == 3 && toggles < 6) begin
                mouse_clicked = ~mouse_clicked;
                toggles++;
            end else begin
                mouse_clicked = 1'b0;
            end
            step();
        end
        frame_tick = 1'b0;
        expect_int("queued transitions", tr_ph.size(), 8);
        exp_seq2 = '{1, 2, 3, 0, 1, 2, 3, 0};
        for (int i = 0; i < 8 && i < tr_ph.size(); i++)
            expect_int($sformatf("queued seq[%0d]", i), tr_ph[i], exp_seq2[i]);
        if (tr_t.size() >= 5) expect_int("idle gap cycles", tr_t[4] - tr_t[3], 1);

        // 5: melee and projectile hit together: 10 then 6 on consecutive cycles
        quiet(2'b01);
        click();
        wait_phase(2, 40, 4);
        clear_obs();
        melee_hit = 1'b1;
        proj_hit = 1'b1;
        step();
        melee_hit = 1'b0;
        proj_hit = 1'b0;
        run(3, 100);
        expect_int("collision strobes", st_amt.size(), 2);
        if (st_amt.size() >= 2) begin
            expect_int("collision first", st_amt[0], 10);
            expect_int("collision second", st_amt[1], 6);
            expect_int("collision spacing", st_t[1] - st_t[0], 1);
        end
        run(80, 4);

        // 6: leaving play mid-ACTIVE, stale pending, async reset mid-WINDUP
        quiet(2'b01);
        click();
        wait_phase(2, 40, 4);
        game_active = 2'b00;
        melee_hit = 1'b1;
        step();
        expect_int("abort phase", int'(attack_phase), 0);
        expect_int("abort strobe", int'(damage_strobe), 0);
        expect_int("abort cooldown_left", int'(cooldown_left), 0);
        quiet(2'b01);
        step();
        click();
        wait_phase(3, 80, 4);
        click();
        game_active = 2'b00;
        step();
        game_active = 2'b01;
        clear_obs();
        run(60, 4);
        expect_int("pending cleared", tr_ph.size(), 0);
        click();
        wait_phase(1, 10, 4);
        #2 rst = 1'b1;
        #1;
        expect_int("async reset outputs", int'({swing_start, fire_req, damage_strobe, attack_phase,
                                                damage_amount, cooldown_left}), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();

        // randomized play
        quiet(2'b01);
        for (int i = 0; i < 3000; i++) begin
            game_active = ($urandom_range(0, 39) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 99) == 0) char_class = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) char_class = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            frame_tick = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 3) == 0) mouse_clicked = ~mouse_clicked;
            projectile_busy = $urandom_range(0, 3) == 0;
            melee_hit = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 3) == 0) proj_hit = ~proj_hit;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
